// File: rtl/mips_cpu_regfile_sb.sv
// mips_cpu_regfile_sb: MIPS-style register file with a per-register scoreboard.
//
// Ports:
//   clk          - single clock; all state updates on the rising edge
//   reset        - synchronous, active-high reset
//   wr_en        - write strobe
//   wr_addr      - write register index
//   wr_data      - write value
//   rsv_en       - marks rsv_addr as having an outstanding producer
//   rsv_addr     - register being reserved
//   rd_en        - per-port read strobes
//   rd_addr      - port i's address in bits [i*ADDR_W +: ADDR_W]
//   rd_data      - port i's registered read data in bits [i*DATA_W +: DATA_W]
//   rd_pending   - per port, set when the value was captured while reserved
//   any_pending  - combinational OR of all stored pending bits
//   debug_reg    - view of register DEBUG_IDX, with same-cycle write forwarding
//
// Configuration:
//   REGFILE_BYPASS_EN - when defined, a read and a write to the same nonzero
//   index in one cycle return wr_data and the post-update pending bit. When
//   undefined, such a read returns the old value and the old pending bit.
//
// Register 0 is hard-wired to zero and can never be reserved.

module mips_cpu_regfile_sb #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned RD_PORTS  = 2,
    parameter int unsigned DEBUG_IDX = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_pending,
    output logic                         any_pending,
    output logic [DATA_W-1:0]            debug_reg
);

    localparam int unsigned       NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DEBUG_IDX);

    logic [DATA_W-1:0]          mem [NREGS];
    logic [NREGS-1:0]           pend_q;
    logic [NREGS-1:0]           pend_d;
    logic                       wr_hit;
    logic                       rsv_hit;
    logic [ADDR_W-1:0]          rd_a [RD_PORTS];
    logic [RD_PORTS*DATA_W-1:0] rd_data_d;
    logic [RD_PORTS-1:0]        rd_pending_d;

    // Accesses to register 0 are dropped here so nothing downstream sees them.
    assign wr_hit  = wr_en  && (wr_addr  != '0);
    assign rsv_hit = rsv_en && (rsv_addr != '0);

    // Unpack per-port read addresses.
    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd_addr
        assign rd_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    // Scoreboard update: a write clears, a reservation sets; the set is
    // applied last so a same-cycle reservation wins over the write.
    always_comb begin
        pend_d = pend_q;
        if (wr_hit) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_hit) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    // Next read-port values; disabled ports hold.
    always_comb begin
        rd_data_d    = rd_data;
        rd_pending_d = rd_pending;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (rd_en[i]) begin
                if (rd_a[i] == '0) begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                    rd_pending_d[i]               = 1'b0;
                end
`ifdef REGFILE_BYPASS_EN
                else if (wr_hit && (wr_addr == rd_a[i])) begin
                    // Forward the in-flight write and its resulting pending bit.
                    rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                    rd_pending_d[i]               = pend_d[rd_a[i]];
                end
`endif
                else begin
                    rd_data_d[i*DATA_W +: DATA_W] = mem[rd_a[i]];
                    rd_pending_d[i]               = pend_q[rd_a[i]];
                end
            end
        end
    end

    // Storage, scoreboard and read-port registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                mem[r] <= '0;
            end
            pend_q     <= '0;
            rd_data    <= '0;
            rd_pending <= '0;
        end else begin
            if (wr_hit) begin
                mem[wr_addr] <= wr_data;
            end
            pend_q     <= pend_d;
            rd_data    <= rd_data_d;
            rd_pending <= rd_pending_d;
        end
    end

    // Stored scoreboard only; no look-ahead on this cycle's reservations.
    assign any_pending = |pend_q;

    // Debug view forwards a same-cycle write to the mirrored register.
    always_comb begin
        if (wr_hit && (wr_addr == DBG_ADDR)) begin
            debug_reg = wr_data;
        end else begin
            debug_reg = mem[DBG_ADDR];
        end
    end

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Directed testbench for mips_cpu_regfile_sb with default parameters.
// Builds with or without REGFILE_BYPASS_EN; expectations follow the define.

module tb_mips_cpu_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NP = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic [NP-1:0]     rd_pending;
    logic              any_pending;
    logic [DW-1:0]     debug_reg;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_d;
    logic          exp_p;

    mips_cpu_regfile_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RD_PORTS (NP),
        .DEBUG_IDX(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .any_pending(any_pending),
        .debug_reg  (debug_reg)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        rsv_en   = 1'b0;
        rd_en    = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    task automatic do_read(input int p, input logic [AW-1:0] a);
        rd_en[p]             = 1'b1;
        rd_addr[p*AW +: AW]  = a;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        idle();
        do_read(0, 5'd5);
        do_read(1, 5'd5);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd0: got %h want %h", rd_data[0 +: DW], 32'h0);
        end
        vectors++;
        if (rd_data[DW +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd1: got %h want %h", rd_data[DW +: DW], 32'h0);
        end
        vectors++;
        if (rd_pending !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pending: got %b want %b", rd_pending, 2'b00);
        end
        vectors++;
        if (any_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_any_pending: got %b want %b", any_pending, 1'b0);
        end
        vectors++;
        if (debug_reg !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_debug: got %h want %h", debug_reg, 32'h0);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        do_write(5'd0, 32'hDEADBEEF);
        tick();
        idle();
        do_read(0, 5'd0);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL r0_read: got %h want %h", rd_data[0 +: DW], 32'h0);
        end
        do_rsv(5'd0);
        tick();
        idle();
        vectors++;
        if (any_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_rsv_any_pending: got %b want %b", any_pending, 1'b0);
        end
    endtask

    task automatic test_bypass();
        idle();
        do_write(5'd7, 32'h12345678);
        do_read(0, 5'd7);
        tick();
        idle();
        exp_d = BYP ? 32'h12345678 : 32'h0;
        vectors++;
        if (rd_data[0 +: DW] !== exp_d) begin
            miscompares++;
            $display("FAIL same_cycle_rd: got %h want %h", rd_data[0 +: DW], exp_d);
        end
        do_read(0, 5'd7);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL next_cycle_rd: got %h want %h", rd_data[0 +: DW], 32'h12345678);
        end
        // Port disabled: output must hold even while r7 changes.
        rd_addr[0 +: AW] = 5'd0;
        do_write(5'd7, 32'h0BADF00D);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rd_hold: got %h want %h", rd_data[0 +: DW], 32'h12345678);
        end
    endtask

    task automatic test_same_addr();
        idle();
        do_write(5'd12, 32'hCAFE0012);
        tick();
        idle();
        do_read(0, 5'd12);
        do_read(1, 5'd12);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'hCAFE0012) begin
            miscompares++;
            $display("FAIL dual_rd0: got %h want %h", rd_data[0 +: DW], 32'hCAFE0012);
        end
        vectors++;
        if (rd_data[DW +: DW] !== 32'hCAFE0012) begin
            miscompares++;
            $display("FAIL dual_rd1: got %h want %h", rd_data[DW +: DW], 32'hCAFE0012);
        end
    endtask

    task automatic test_pending();
        idle();
        do_rsv(5'd9);
        tick();
        idle();
        vectors++;
        if (any_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_any_pending: got %b want %b", any_pending, 1'b1);
        end
        do_read(0, 5'd9);
        tick();
        idle();
        vectors++;
        if (rd_pending[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_rd_pending: got %b want %b", rd_pending[0], 1'b1);
        end
        // Reservation and write together: reservation wins.
        do_write(5'd9, 32'hA5);
        do_rsv(5'd9);
        tick();
        idle();
        do_read(1, 5'd9);
        tick();
        idle();
        vectors++;
        if (rd_pending[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL rsv_wins_pending: got %b want %b", rd_pending[1], 1'b1);
        end
        vectors++;
        if (rd_data[DW +: DW] !== 32'hA5) begin
            miscompares++;
            $display("FAIL rsv_wins_data: got %h want %h", rd_data[DW +: DW], 32'hA5);
        end
        // Double reservation is not counted: one write clears it.
        do_rsv(5'd9);
        tick();
        idle();
        do_write(5'd9, 32'hA6);
        tick();
        idle();
        vectors++;
        if (any_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_clears_any: got %b want %b", any_pending, 1'b0);
        end
        do_read(1, 5'd9);
        tick();
        idle();
        vectors++;
        if (rd_data[DW +: DW] !== 32'hA6) begin
            miscompares++;
            $display("FAIL wr_clears_data: got %h want %h", rd_data[DW +: DW], 32'hA6);
        end
        vectors++;
        if (rd_pending[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_clears_pending: got %b want %b", rd_pending[1], 1'b0);
        end
        // Same-cycle read of a clearing write: post-update bit only with bypass.
        do_rsv(5'd9);
        tick();
        idle();
        do_write(5'd9, 32'hB0);
        do_read(0, 5'd9);
        tick();
        idle();
        exp_d = BYP ? 32'hB0 : 32'hA6;
        exp_p = BYP ? 1'b0 : 1'b1;
        vectors++;
        if (rd_data[0 +: DW] !== exp_d) begin
            miscompares++;
            $display("FAIL clr_same_cycle_data: got %h want %h", rd_data[0 +: DW], exp_d);
        end
        vectors++;
        if (rd_pending[0] !== exp_p) begin
            miscompares++;
            $display("FAIL clr_same_cycle_pending: got %b want %b", rd_pending[0], exp_p);
        end
    endtask

    task automatic test_debug();
        idle();
        do_write(5'd2, 32'h55);
        #1;
        vectors++;
        if (debug_reg !== 32'h55) begin
            miscompares++;
            $display("FAIL debug_fwd: got %h want %h", debug_reg, 32'h55);
        end
        tick();
        idle();
        wr_addr = 5'd2;
        wr_data = 32'hAA;
        #1;
        vectors++;
        if (debug_reg !== 32'h55) begin
            miscompares++;
            $display("FAIL debug_stored: got %h want %h", debug_reg, 32'h55);
        end
        do_write(5'd3, 32'h99);
        #1;
        vectors++;
        if (debug_reg !== 32'h55) begin
            miscompares++;
            $display("FAIL debug_other_wr: got %h want %h", debug_reg, 32'h55);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_override();
        idle();
        do_rsv(5'd3);
        do_write(5'd4, 32'h77);
        tick();
        idle();
        do_read(0, 5'd4);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h77) begin
            miscompares++;
            $display("FAIL pre_reset_r4: got %h want %h", rd_data[0 +: DW], 32'h77);
        end
        vectors++;
        if (any_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_any: got %b want %b", any_pending, 1'b1);
        end
        reset = 1'b1;
        do_write(5'd4, 32'h99);
        do_rsv(5'd5);
        do_read(0, 5'd4);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rd_cleared: got %h want %h", rd_data[0 +: DW], 32'h0);
        end
        vectors++;
        if (any_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_any_cleared: got %b want %b", any_pending, 1'b0);
        end
        do_read(0, 5'd4);
        do_read(1, 5'd2);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_r4: got %h want %h", rd_data[0 +: DW], 32'h0);
        end
        vectors++;
        if (rd_data[DW +: DW] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_r2: got %h want %h", rd_data[DW +: DW], 32'h0);
        end
        // Discarded reservation does not block a later write.
        do_write(5'd3, 32'h33);
        tick();
        idle();
        do_read(0, 5'd3);
        tick();
        idle();
        vectors++;
        if (rd_data[0 +: DW] !== 32'h33) begin
            miscompares++;
            $display("FAIL post_reset_wr: got %h want %h", rd_data[0 +: DW], 32'h33);
        end
        vectors++;
        if (rd_pending[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_pending: got %b want %b", rd_pending[0], 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        rd_en    = '0;
        rd_addr  = '0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_same_addr();
        test_pending();
        test_debug();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
